// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and sequencing controller for a 5-stage RV32I pipeline.
// It keeps a shadow copy of the E/M/W destination info, and from that it drives
// the stage stall/flush controls and the E-stage forwarding selects.
// Optional build macro HAZARD_PERF_EN adds saturating stall/flush event counters.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal issue; branch flush or first load-use bubble decided here
// LD_STALL | extra load-use bubbles for a multi-cycle data RAM (cnt counts down)
module hazard_ctrl #(
  parameter int AW              = 5,
  parameter int LD_STALL_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_d_i,
  input  logic [AW-1:0] rs1_d_i,
  input  logic [AW-1:0] rs2_d_i,
  input  logic [AW-1:0] rd_d_i,
  input  logic          reg_write_d_i,
  input  logic          load_d_i,
  input  logic          pcsrc_e_i,
  output logic          stall_f_o,
  output logic          stall_d_o,
  output logic          flush_d_o,
  output logic          flush_e_o,
  output logic [1:0]    fwd_a_o,
  output logic [1:0]    fwd_b_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]   stall_cnt_o,
  output logic [31:0]   flush_cnt_o
`endif
);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd;
    logic          regWrite;
    logic          load;
  } entE_t;

  // Later stages only ever act as forwarding producers, so only the
  // producer fields are kept for M and W.
  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic          regWrite;
  } entWb_t;

  typedef enum logic {RUN, LD_STALL} state_t;

  localparam logic [2:0] CNT_INIT = 3'(LD_STALL_CYCLES - 1);

  state_t     state, stateNext;
  logic [2:0] cnt, cntNext;
  entE_t      entD, entE;
  entWb_t     entM, entW;
  logic       hz;

  assign entD = {valid_d_i, rs1_d_i, rs2_d_i, rd_d_i, reg_write_d_i, load_d_i};

  assign hz = valid_d_i & entE.valid & entE.load & entE.regWrite &
              (entE.rd != '0) & ((entE.rd == rs1_d_i) | (entE.rd == rs2_d_i));

  function automatic logic [1:0] fwdSel(input logic [AW-1:0] src,
                                        input entWb_t m, input entWb_t w);
    if (src == '0)                                  return 2'b00;
    else if (m.valid && m.regWrite && m.rd == src)  return 2'b10;
    else if (w.valid && w.regWrite && w.rd == src)  return 2'b01;
    else                                            return 2'b00;
  endfunction

  // Shadow scoreboard shifts every cycle; E takes a bubble whenever it is flushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      entE <= '0;
      entM <= '0;
      entW <= '0;
    end else begin
      entW <= entM;
      entM <= {entE.valid, entE.rd, entE.regWrite};
      entE <= flush_e_o ? '0 : entD;
    end
  end

  // State register and bubble counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Next-state and stall/flush decode; a redirect always beats a load-use stall.
  always_comb begin
    stall_f_o = 1'b0;
    stall_d_o = 1'b0;
    flush_d_o = 1'b0;
    flush_e_o = 1'b0;
    stateNext = state;
    cntNext   = cnt;
    if (rst) begin
      flush_d_o = 1'b1;
      flush_e_o = 1'b1;
      stateNext = RUN;
      cntNext   = '0;
    end else begin
      case (state)
        RUN: begin
          if (pcsrc_e_i) begin
            flush_d_o = 1'b1;
            flush_e_o = 1'b1;
          end else if (hz) begin
            stall_f_o = 1'b1;
            stall_d_o = 1'b1;
            flush_e_o = 1'b1;
            cntNext   = CNT_INIT;
            if (LD_STALL_CYCLES > 1) stateNext = LD_STALL;
          end
        end
        LD_STALL: begin
          if (pcsrc_e_i) begin
            flush_d_o = 1'b1;
            flush_e_o = 1'b1;
            stateNext = RUN;
            cntNext   = '0;
          end else begin
            stall_f_o = 1'b1;
            stall_d_o = 1'b1;
            flush_e_o = 1'b1;
            // cnt reaching zero at this edge ends the stall
            if (cnt <= 3'd1) begin
              stateNext = RUN;
              cntNext   = '0;
            end else begin
              cntNext = cnt - 3'd1;
            end
          end
        end
        default: stateNext = RUN;
      endcase
    end
  end

  // Forwarding selects for the instruction currently in E; M beats W.
  always_comb begin
    fwd_a_o = 2'b00;
    fwd_b_o = 2'b00;
    if (!rst) begin
      fwd_a_o = fwdSel(entE.rs1, entM, entW);
      fwd_b_o = fwdSel(entE.rs2, entM, entW);
    end
  end

`ifdef HAZARD_PERF_EN
  // Saturating event counters for stall and front-end flush cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_f_o && stall_cnt_o != 32'hFFFF_FFFF) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (flush_d_o && flush_cnt_o != 32'hFFFF_FFFF) flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (1, 3 and 4 load-use bubbles) share one
// stimulus stream; a pipeline-level reference model predicts each cycle's
// controls into a queue that a negedge monitor drains and compares.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       validD = 1'b0, rwD = 1'b0, ldD = 1'b0, pcsrc = 1'b0;
  logic [4:0] rs1D = '0, rs2D = '0, rdD = '0;

  logic       sF [3];
  logic       sD [3];
  logic       fD [3];
  logic       fE [3];
  logic [1:0] fA [3];
  logic [1:0] fB [3];
`ifdef HAZARD_PERF_EN
  logic [31:0] sCnt [3];
  logic [31:0] fCnt [3];
`endif

  for (genvar g = 0; g < 3; g++) begin : gDut
    localparam int NV = (g == 0) ? 1 : (g == 1) ? 3 : 4;
    hazard_ctrl #(.AW(5), .LD_STALL_CYCLES(NV)) uDut (
      .clk          (clk),
      .rst          (rst),
      .valid_d_i    (validD),
      .rs1_d_i      (rs1D),
      .rs2_d_i      (rs2D),
      .rd_d_i       (rdD),
      .reg_write_d_i(rwD),
      .load_d_i     (ldD),
      .pcsrc_e_i    (pcsrc),
      .stall_f_o    (sF[g]),
      .stall_d_o    (sD[g]),
      .flush_d_o    (fD[g]),
      .flush_e_o    (fE[g]),
      .fwd_a_o      (fA[g]),
      .fwd_b_o      (fB[g])
`ifdef HAZARD_PERF_EN
      ,
      .stall_cnt_o  (sCnt[g]),
      .flush_cnt_o  (fCnt[g])
`endif
    );
  end

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          k;
    logic [7:0]  ctl;   // {stallF, stallD, flushD, flushE, fwdA, fwdB}
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2, rd;
    logic       rw, ld;
  } ins_t;

  // pipe[k][0..2] = instruction in E, M, W for instance k
  ins_t        pipe [3][3];
  int          stallLeft [3];
  logic [31:0] mSc [3];
  logic [31:0] mFc [3];
  logic        eStallF [3];
  logic        eFlushD [3];
  logic        eFlushE [3];

  function automatic int nOf(input int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 4;
  endfunction

  function automatic logic [1:0] fwdOf(input int k, input logic [4:0] src);
    if (src == 0) return 2'b00;
    if (pipe[k][1].v && pipe[k][1].rw && pipe[k][1].rd == src) return 2'b10;
    if (pipe[k][2].v && pipe[k][2].rw && pipe[k][2].rd == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic loadUse(input int k);
    ins_t e;
    e = pipe[k][0];
    return validD && e.v && e.ld && e.rw && e.rd != 0 && (e.rd == rs1D || e.rd == rs2D);
  endfunction

  // Expected controls for the inputs now applied; pushed for the monitor.
  task automatic predict();
    for (int k = 0; k < 3; k++) begin
      exp_t x;
      logic sf, sd, fd, fe;
      logic [1:0] a, b;
      sf = 0; sd = 0; fd = 0; fe = 0; a = 0; b = 0;
      if (rst) begin
        fd = 1; fe = 1;
      end else begin
        if (pcsrc) begin
          fd = 1; fe = 1;
        end else if (stallLeft[k] > 0 || loadUse(k)) begin
          sf = 1; sd = 1; fe = 1;
        end
        a = fwdOf(k, pipe[k][0].rs1);
        b = fwdOf(k, pipe[k][0].rs2);
      end
      eStallF[k] = sf; eFlushD[k] = fd; eFlushE[k] = fe;
      x.k = k; x.ctl = {sf, sd, fd, fe, a, b}; x.sc = mSc[k]; x.fc = mFc[k];
      q.push_back(x);
    end
  endtask

  // Clock-edge update of the model using the inputs that were applied.
  task automatic advance();
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        for (int s = 0; s < 3; s++) pipe[k][s] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0};
        stallLeft[k] = 0;
        mSc[k] = 0;
        mFc[k] = 0;
      end else begin
        logic hzNow;
        hzNow = loadUse(k);
        if (eStallF[k] && mSc[k] != 32'hFFFF_FFFF) mSc[k]++;
        if (eFlushD[k] && mFc[k] != 32'hFFFF_FFFF) mFc[k]++;
        if (pcsrc)                  stallLeft[k] = 0;
        else if (stallLeft[k] > 0)  stallLeft[k]--;
        else if (hzNow)             stallLeft[k] = nOf(k) - 1;
        pipe[k][2] = pipe[k][1];
        pipe[k][1] = pipe[k][0];
        if (eFlushE[k]) pipe[k][0] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0};
        else            pipe[k][0] = '{validD, rs1D, rs2D, rdD, rwD, ldD};
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [4:0] d,
                      input logic w, input logic l, input logic p);
    @(posedge clk);
    advance();
    #1;
    rst = r; validD = v; rs1D = s1; rs2D = s2; rdD = d; rwD = w; ldD = l; pcsrc = p;
    predict();
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare every predicted cycle against the matching instance.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [7:0] act;
      e = q.pop_front();
      act = {sF[e.k], sD[e.k], fD[e.k], fE[e.k], fA[e.k], fB[e.k]};
      total++;
      if (act !== e.ctl) begin
        bad++;
        $display("FAIL ctl inst%0d t=%0t got=%b want=%b", e.k, $time, act, e.ctl);
      end
`ifdef HAZARD_PERF_EN
      total++;
      if (sCnt[e.k] !== e.sc || fCnt[e.k] !== e.fc) begin
        bad++;
        $display("FAIL perf inst%0d t=%0t got=%0d/%0d want=%0d/%0d",
                 e.k, $time, sCnt[e.k], fCnt[e.k], e.sc, e.fc);
      end
`endif
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      eStallF[k] = 0; eFlushD[k] = 1; eFlushE[k] = 1;
      stallLeft[k] = 0; mSc[k] = 0; mFc[k] = 0;
    end
    // reset
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    nop(2);
    // ALU forward from M: addi x5 ; add x6,x5,x5
    step(0, 1, 0, 0, 5, 1, 0, 0);
    step(0, 1, 5, 5, 6, 1, 0, 0);
    nop(3);
    // forward from W with one nop between
    step(0, 1, 0, 0, 5, 1, 0, 0);
    nop(1);
    step(0, 1, 5, 5, 6, 1, 0, 0);
    nop(3);
    // double producer, M priority
    step(0, 1, 0, 0, 5, 1, 0, 0);
    step(0, 1, 0, 0, 5, 1, 0, 0);
    step(0, 1, 5, 0, 7, 1, 0, 0);
    nop(3);
    // load-use: lw x8 ; add x9,x8,x0 held in D
    step(0, 1, 0, 0, 8, 1, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 8, 0, 9, 1, 0, 0);
    nop(4);
    // x0 guard: lw x0 ; add x1,x0,x0
    step(0, 1, 0, 0, 0, 1, 1, 0);
    step(0, 1, 0, 0, 1, 1, 0, 0);
    nop(3);
    // branch beats load-use
    step(0, 1, 0, 0, 8, 1, 1, 0);
    step(0, 1, 8, 0, 9, 1, 0, 1);
    nop(3);
    // reset in the second stall cycle
    step(0, 1, 0, 0, 8, 1, 1, 0);
    step(0, 1, 8, 0, 9, 1, 0, 0);
    step(1, 1, 8, 0, 9, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 8, 0, 9, 1, 0, 0);
    nop(3);
    // randomized traffic on a small register set to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 1),
           ($urandom_range(0, 99) < 85),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 99) < 70),
           ($urandom_range(0, 99) < 35),
           ($urandom_range(0, 99) < 8));
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipelined RV32I core (F/D/E/M/W).
- Keeps a shadow scoreboard of in-flight destination registers and drives the stage-register stall and flush controls.
- Drives the E-stage operand forwarding selects and inserts load-use stalls and branch/jump flushes.
- Sits beside the pipeline registers. It consumes D-stage instruction fields and the E-stage taken-branch signal. It does not touch the datapath values.

Parameters:
- AW, 5, register address width.
- LD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7; >1 for multi-cycle data RAM).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- valid_d_i  input  1  D-stage slot holds a real instruction
- rs1_d_i  input  AW  D-stage source 1
- rs2_d_i  input  AW  D-stage source 2
- rd_d_i  input  AW  D-stage destination
- reg_write_d_i  input  1  D instruction writes rd
- load_d_i  input  1  D instruction is a load (ResultSrc=mem)
- pcsrc_e_i  input  1  E-stage branch taken / JAL / JALR redirect
- stall_f_o  output  1  hold PC
- stall_d_o  output  1  hold F/D register
- flush_d_o  output  1  clear F/D register to bubble
- flush_e_o  output  1  clear D/E register to bubble
- fwd_a_o  output  2  E SrcA select: 00 regfile, 01 W result, 10 M ALU result
- fwd_b_o  output  2  E SrcB select, same encoding

Behaviour:
- Shadow scoreboard: three entries E, M, W. Each entry holds {valid, rs1, rs2, rd, reg_write, load}.
  - Each cycle W<=M and M<=E.
  - E<=D fields if no flush_e_o and no stall; otherwise E<=bubble (valid=0).
- Entries with rd=0 never match a source, and never forward or stall.
- Forwarding (combinational on shadow E sources):
  - fwd_a_o=10 if M.valid & M.reg_write & M.rd==E.rs1 & E.rs1!=0.
  - Otherwise fwd_a_o=01 if the same condition holds on W.
  - Otherwise fwd_a_o=00.
  - M has priority over W. fwd_b_o is identical using rs2.
- Load-use detect:
  - hz = valid_d_i & E.valid & E.load & E.reg_write & E.rd!=0 & (E.rd==rs1_d_i | E.rd==rs2_d_i).
- FSM states RUN, LD_STALL. cnt is a 3-bit counter.
  - RUN:
    - If pcsrc_e_i: flush_d_o=flush_e_o=1, stall=0, stay in RUN. The branch has priority over hz.
    - Else if hz: stall_f_o=stall_d_o=flush_e_o=1, cnt<=LD_STALL_CYCLES-1, go to LD_STALL if LD_STALL_CYCLES>1, else stay in RUN.
  - LD_STALL:
    - stall_f_o=stall_d_o=flush_e_o=1 and cnt decrements.
    - When cnt==0 at the clock edge, go to RUN.
    - pcsrc_e_i cannot occur here, because E holds a bubble. If it is asserted anyway, it wins: flush_d_o=flush_e_o=1, stall=0, go to RUN.
  - Total stall length for one hazard is exactly LD_STALL_CYCLES cycles.
  - A non-load producer (ALU) in E never stalls; it is covered by forwarding.
- All control outputs are combinational from state, scoreboard and inputs. They are valid in the same cycle as the hazard.
- Reset (rst high at the edge):
  - state<=RUN, cnt<=0, all scoreboard valid<=0.
  - While rst is high: flush_d_o=flush_e_o=1, stall_f_o=stall_d_o=0, fwd_a_o=fwd_b_o=00.
- Reset mid-stall aborts the stall; the first cycle after reset is in RUN with an empty scoreboard.
- stall_d_o and flush_d_o are never both 1.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined, add outputs stall_cnt_o [31:0] and flush_cnt_o [31:0]:
  - stall_cnt_o increments on every cycle with stall_f_o=1.
  - flush_cnt_o increments on every cycle with flush_d_o=1 while rst=0.
  - Both saturate at 32'hFFFF_FFFF and clear to 0 on rst.
- When undefined, neither port nor counters exist and behaviour is otherwise identical.

Test Plan:
- ALU forwarding: addi x5,x0,7 then add x6,x5,x5 → when the add is in E, fwd_a_o=fwd_b_o=10 and no stall. With one nop between, both selects are 01.
- Double producer: addi x5 then addi x5 then add x7,x5,x0 → fwd_a_o=10, confirming M priority over W.
- Load-use with LD_STALL_CYCLES=1: lw x8,0(x0) then add x9,x8,x0 → exactly 1 cycle of stall_f_o=stall_d_o=flush_e_o=1, then fwd_a_o=01 for the add. With LD_STALL_CYCLES=3, 3 stall cycles.
- x0 guard: lw x0 followed by add x1,x0,x0 → no stall, fwd selects 00.
- Branch: pcsrc_e_i=1 for one cycle while hz=1 in D → flush_d_o=flush_e_o=1, stall=0. Next cycle E.valid=0 and no forwarding from the flushed slot.
- Reset mid-stall (LD_STALL_CYCLES=4, rst in 2nd stall cycle) → outputs at reset values, then RUN with no stall. With HAZARD_PERF_EN, stall_cnt_o=0 after reset.
